// File: rtl/pipeline_ctrl.sv
// Debug/run controller for the MIPS pipeline: gates stage enables for free-run,
// single-step and halt-drain, and streams out the register bank on request.
module pipeline_ctrl #(
   parameter int REG_ADDR_BITS = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int CNT_WIDTH     = 32,
   parameter int DRAIN_CYCLES  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic                     halt_in,
   output logic                     pipe_en,
   output logic                     pc_hold,
   output logic                     pc_clear,
   output logic [REG_ADDR_BITS-1:0] dbg_reg_addr,
   input  logic [DATA_WIDTH-1:0]    dbg_reg_data,
   output logic [DATA_WIDTH-1:0]    dump_data,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic                     program_done,
   output logic [CNT_WIDTH-1:0]     cycle_count
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_STEP  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_DUMP  = 3'd5;

   localparam logic [2:0] OP_RUN   = 3'd1;
   localparam logic [2:0] OP_STEP  = 3'd2;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_DUMP  = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   logic [2:0] state;
   logic [2:0] ret_state;
   logic [3:0] drain_cnt;
   logic       pc_clear_q;
   logic       cmd_fire;
   logic       dump_fire;
   logic       last_addr;

   assign cmd_ready    = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
   assign pipe_en      = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
   assign pc_hold      = (state == ST_DRAIN);
   assign pc_clear     = pc_clear_q;
   assign dump_valid   = (state == ST_DUMP);
   assign dump_data    = dbg_reg_data;
   // A dump started from DONE keeps reporting the halted program as finished.
   assign program_done = (state == ST_DONE) || ((state == ST_DUMP) && (ret_state == ST_DONE));

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign dump_fire = dump_valid && dump_ready;
   assign last_addr = (dbg_reg_addr == {REG_ADDR_BITS{1'b1}});

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         ret_state    <= ST_IDLE;
         drain_cnt    <= '0;
         pc_clear_q   <= 1'b0;
         dbg_reg_addr <= '0;
         cycle_count  <= '0;
      end else begin
         pc_clear_q <= 1'b0;

         if (pipe_en && (cycle_count != {CNT_WIDTH{1'b1}})) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
         end

         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  case (cmd_op)
                     OP_RUN:  state <= ST_RUN;
                     OP_STEP: state <= ST_STEP;
                     OP_DUMP: begin
                        state        <= ST_DUMP;
                        ret_state    <= ST_IDLE;
                        dbg_reg_addr <= '0;
                     end
                     OP_CLEAR: begin
                        pc_clear_q  <= 1'b1;
                        cycle_count <= '0;
                     end
                     default: ;
                  endcase
               end
            end

            ST_RUN: begin
               // Halt and STOP together still load the counter only once.
               if (halt_in || (cmd_fire && (cmd_op == OP_STOP))) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end

            ST_STEP: begin
               if (halt_in) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_DRAIN: begin
               drain_cnt <= drain_cnt - 4'd1;
               if (drain_cnt == 4'd1) begin
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (cmd_fire) begin
                  case (cmd_op)
                     OP_DUMP: begin
                        state        <= ST_DUMP;
                        ret_state    <= ST_DONE;
                        dbg_reg_addr <= '0;
                     end
                     OP_CLEAR: begin
                        state       <= ST_IDLE;
                        pc_clear_q  <= 1'b1;
                        cycle_count <= '0;
                     end
                     default: ;
                  endcase
               end
            end

            ST_DUMP: begin
               if (dump_fire) begin
                  if (last_addr) begin
                     dbg_reg_addr <= '0;
                     state        <= ret_state;
                  end else begin
                     dbg_reg_addr <= dbg_reg_addr + REG_ADDR_BITS'(1);
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: step, run/halt drain, STOP+halt collision,
// register dump with back-pressure, clear, reset mid-dump and counter saturation.
module tb_pipeline_ctrl;

   localparam int RAB = 5;
   localparam int DW  = 32;
   localparam int CW  = 5;
   localparam int DC  = 4;

   localparam logic [2:0] OP_RUN   = 3'd1;
   localparam logic [2:0] OP_STEP  = 3'd2;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_DUMP  = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [2:0]     cmd_op = 3'd0;
   logic           halt_in = 1'b0;
   logic           pipe_en;
   logic           pc_hold;
   logic           pc_clear;
   logic [RAB-1:0] dbg_reg_addr;
   logic [DW-1:0]  dbg_reg_data;
   logic [DW-1:0]  dump_data;
   logic           dump_valid;
   logic           dump_ready = 1'b0;
   logic           program_done;
   logic [CW-1:0]  cycle_count;

   int checks = 0;
   int errors = 0;

   pipeline_ctrl #(
      .REG_ADDR_BITS(RAB),
      .DATA_WIDTH   (DW),
      .CNT_WIDTH    (CW),
      .DRAIN_CYCLES (DC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .halt_in     (halt_in),
      .pipe_en     (pipe_en),
      .pc_hold     (pc_hold),
      .pc_clear    (pc_clear),
      .dbg_reg_addr(dbg_reg_addr),
      .dbg_reg_data(dbg_reg_data),
      .dump_data   (dump_data),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .program_done(program_done),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   // Register bank stand-in: each address reads back a distinct pattern.
   function automatic logic [DW-1:0] reg_word(input int k);
      return 32'hC0DE_0000 | (32'(k) * 32'h11);
   endfunction

   assign dbg_reg_data = reg_word(int'(dbg_reg_addr));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int pe_cnt;
      int ph_cnt;
      int first_hold;
      int k;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_pipe_en", 32'(pipe_en), 32'd0);
      check("rst_pc_hold", 32'(pc_hold), 32'd0);
      check("rst_pc_clear", 32'(pc_clear), 32'd0);
      check("rst_dump_valid", 32'(dump_valid), 32'd0);
      check("rst_program_done", 32'(program_done), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_cycle_count", 32'(cycle_count), 32'd0);
      check("rst_addr", 32'(dbg_reg_addr), 32'd0);
      rst = 1'b0;

      // Single step: one enabled cycle, then back to idle
      send_cmd(OP_STEP);
      check("step_pipe_en", 32'(pipe_en), 32'd1);
      check("step_cmd_ready", 32'(cmd_ready), 32'd0);
      check("step_pc_hold", 32'(pc_hold), 32'd0);
      tick();
      check("step_after_pipe_en", 32'(pipe_en), 32'd0);
      check("step_after_cmd_ready", 32'(cmd_ready), 32'd1);
      check("step_cycle_count", 32'(cycle_count), 32'd1);
      check("step_program_done", 32'(program_done), 32'd0);

      // Clear from idle
      send_cmd(OP_CLEAR);
      check("clr_idle_pulse", 32'(pc_clear), 32'd1);
      check("clr_idle_count", 32'(cycle_count), 32'd0);
      check("clr_idle_pipe_en", 32'(pipe_en), 32'd0);
      tick();
      check("clr_idle_pulse_end", 32'(pc_clear), 32'd0);

      // Run, halt seen in 11th run cycle, drain 4 cycles
      send_cmd(OP_RUN);
      pe_cnt = 0;
      ph_cnt = 0;
      first_hold = 0;
      for (int i = 1; i <= 20; i++) begin
         halt_in = (i == 11);
         if (pipe_en) pe_cnt++;
         if (pc_hold) begin
            ph_cnt++;
            if (first_hold == 0) first_hold = i;
         end
         tick();
      end
      halt_in = 1'b0;
      check("run_pipe_en_cycles", 32'(pe_cnt), 32'd15);
      check("run_pc_hold_cycles", 32'(ph_cnt), 32'd4);
      check("run_first_hold", 32'(first_hold), 32'd12);
      check("run_program_done", 32'(program_done), 32'd1);
      check("run_cycle_count", 32'(cycle_count), 32'd15);
      check("run_done_pipe_en", 32'(pipe_en), 32'd0);

      // RUN in DONE is ignored
      send_cmd(OP_RUN);
      check("done_run_pipe_en", 32'(pipe_en), 32'd0);
      check("done_run_program_done", 32'(program_done), 32'd1);
      tick();
      check("done_run_pipe_en2", 32'(pipe_en), 32'd0);
      check("done_run_count", 32'(cycle_count), 32'd15);

      // Dump from DONE with dump_ready toggling
      send_cmd(OP_DUMP);
      k = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (k == 32) break;
         dump_ready = ((cyc % 2) == 0);
         check("dump_valid", 32'(dump_valid), 32'd1);
         check("dump_addr", 32'(dbg_reg_addr), 32'(k));
         check("dump_data", dump_data, reg_word(k));
         check("dump_program_done", 32'(program_done), 32'd1);
         if (dump_ready) k++;
         tick();
      end
      dump_ready = 1'b0;
      check("dump_word_count", 32'(k), 32'd32);
      check("dump_end_valid", 32'(dump_valid), 32'd0);
      check("dump_end_program_done", 32'(program_done), 32'd1);
      check("dump_end_addr", 32'(dbg_reg_addr), 32'd0);
      check("dump_end_cmd_ready", 32'(cmd_ready), 32'd1);

      // Clear from DONE
      send_cmd(OP_CLEAR);
      check("clr_done_pulse", 32'(pc_clear), 32'd1);
      check("clr_done_count", 32'(cycle_count), 32'd0);
      check("clr_done_program_done", 32'(program_done), 32'd0);
      check("clr_done_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      check("clr_done_pulse_end", 32'(pc_clear), 32'd0);
      check("clr_done_pipe_en", 32'(pipe_en), 32'd0);

      // STOP and halt in the same RUN cycle: one drain only
      send_cmd(OP_RUN);
      tick();
      tick();
      tick();
      cmd_valid = 1'b1;
      cmd_op    = OP_STOP;
      halt_in   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      halt_in   = 1'b0;
      pe_cnt = 0;
      ph_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (pipe_en) pe_cnt++;
         if (pc_hold) ph_cnt++;
         tick();
      end
      check("stop_halt_drain_cycles", 32'(ph_cnt), 32'd4);
      check("stop_halt_pipe_en_cycles", 32'(pe_cnt), 32'd4);
      check("stop_halt_program_done", 32'(program_done), 32'd1);
      check("stop_halt_count", 32'(cycle_count), 32'd8);

      // Dump from IDLE, reset at address 7
      send_cmd(OP_CLEAR);
      tick();
      send_cmd(OP_DUMP);
      check("idump_valid", 32'(dump_valid), 32'd1);
      check("idump_program_done", 32'(program_done), 32'd0);
      dump_ready = 1'b1;
      repeat (7) tick();
      dump_ready = 1'b0;
      check("idump_addr7", 32'(dbg_reg_addr), 32'd7);
      check("idump_data7", dump_data, reg_word(7));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_dump_valid_mid", 32'(dump_valid), 32'd0);
      check("rst_dump_addr_mid", 32'(dbg_reg_addr), 32'd0);
      check("rst_dump_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_dump_program_done", 32'(program_done), 32'd0);

      // Counter saturation at all-ones during a long run
      send_cmd(OP_RUN);
      repeat (40) tick();
      check("sat_count", 32'(cycle_count), 32'd31);
      check("sat_pipe_en", 32'(pipe_en), 32'd1);
      repeat (3) tick();
      check("sat_count_hold", 32'(cycle_count), 32'd31);
      send_cmd(OP_STOP);
      check("sat_stop_pc_hold", 32'(pc_hold), 32'd1);
      repeat (4) tick();
      check("sat_program_done", 32'(program_done), 32'd1);
      check("sat_count_final", 32'(cycle_count), 32'd31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Debug/run controller that sequences the MIPS pipeline: gates stage enables for free-run, single-step and halt-drain, and walks the register bank read ports to dump all registers through a valid/ready stream.
- Sits between the host debug command interface and the IF/ID/EX/MEM/WB stages, including the ID-stage register bank.
- Commands arrive from the debug front end; halt detection comes from the ID-stage decoder.

Parameters:
- REG_ADDR_BITS, 5, register bank address width; the dump covers 2^REG_ADDR_BITS registers.
- DATA_WIDTH, 32, register data width.
- CNT_WIDTH, 32, cycle counter width.
- DRAIN_CYCLES, 4, cycles needed to retire in-flight instructions after halt (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a clk edge.
- cmd_op  in  3  0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 DUMP, 5 CLEAR; codes 6-7 are accepted and ignored.
- halt_in  in  1  ID decoder saw HALT opcode; valid only while pipe_en=1.
- pipe_en  out  1  enable for all pipeline registers and PC.
- pc_hold  out  1  freeze PC and IF/ID (fetch bubbles) while downstream drains.
- pc_clear  out  1  one-cycle PC reset pulse.
- dbg_reg_addr  out  REG_ADDR_BITS  register bank debug read address.
- dbg_reg_data  in  DATA_WIDTH  combinational read data for dbg_reg_addr.
- dump_data  out  DATA_WIDTH  dumped register value.
- dump_valid  out  1  dump_data valid.
- dump_ready  in  1  consumer accepts dump word.
- program_done  out  1  program halted and drained.
- cycle_count  out  CNT_WIDTH  count of cycles with pipe_en=1; saturates at all-ones.

Behaviour:
- Moore FSM. States: IDLE, RUN, STEP, DRAIN, DONE, DUMP. All outputs decode from state and registers; a change takes effect the cycle after the causing edge.
- Reset: state=IDLE, cycle_count=0, dbg_reg_addr=0, drain counter=0, return-state=IDLE. pipe_en, pc_hold, pc_clear, dump_valid and program_done are 0. cmd_ready=1. A reset mid-DUMP or mid-DRAIN aborts immediately.
- cmd_ready=1 in IDLE, RUN and DONE; 0 in STEP, DRAIN and DUMP.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - DUMP -> DUMP with return-state=IDLE and dbg_reg_addr=0.
  - CLEAR -> pc_clear=1 for the next cycle, cycle_count=0, stay IDLE.
  - STOP and NOP have no effect.
- RUN: pipe_en=1.
  - halt_in=1 or an accepted STOP -> DRAIN with drain counter=DRAIN_CYCLES.
  - Both in the same cycle count as one entry.
  - All other commands are accepted and ignored.
- STEP: pipe_en=1 for exactly one cycle. halt_in=1 in that cycle -> DRAIN; otherwise -> IDLE.
- DRAIN: pipe_en=1 and pc_hold=1; the counter decrements each cycle. On the cycle the counter is 1 -> DONE, so pipe_en=1 for exactly DRAIN_CYCLES cycles. halt_in is ignored.
- DONE: program_done=1 and pipe_en=0.
  - DUMP -> DUMP with return-state=DONE.
  - CLEAR -> pc_clear pulse, cycle_count=0, -> IDLE.
  - RUN, STEP and STOP are ignored.
- DUMP: dump_valid=1 and dump_data=dbg_reg_data.
  - On dump_valid&dump_ready, dbg_reg_addr increments.
  - When the last address (2^REG_ADDR_BITS-1) is accepted, dbg_reg_addr returns to 0 and the FSM goes to return-state.
  - dump_valid stays 1 with data stable until accepted.
  - program_done stays as in return-state.
- cycle_count increments by 1 on every edge where pipe_en=1 and saturates at all-ones (no wrap).

Test Plan:
- Reset then STEP accepted at edge N -> pipe_en=1 only during cycle N+1; state returns to IDLE; cycle_count=1; cmd_ready returns to 1 at N+2.
- RUN, then halt_in=1 after 10 run cycles, DRAIN_CYCLES=4 -> pipe_en high for 15 cycles, pc_hold high for the last 4, then program_done=1 and cycle_count=15.
- In RUN, STOP accepted in the same cycle halt_in=1 -> single DRAIN of exactly 4 cycles, then DONE; no double entry.
- DUMP from DONE, dump_ready toggling 1/0 -> 32 words in address order 0..31 with data held across stalls; after word 31 program_done is still 1 and dbg_reg_addr=0.
- DONE then RUN -> ignored (pipe_en stays 0). CLEAR -> pc_clear=1 for one cycle, cycle_count=0, state IDLE, program_done=0.
- rst asserted during DUMP at address 7 -> next cycle dump_valid=0, dbg_reg_addr=0, state IDLE. Separately, force cycle_count to all-ones in RUN -> it holds all-ones.
